alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/issue stage that produces the ALU's operation select and operands.
- Accepts one fetched instruction per cycle with its PC and register-file read data, decodes RV32I OP, OP-IMM, LUI and AUIPC into a pkg t_alu_op plus two 32-bit operands, and holds the result in a 2-entry valid/ready output buffer.
- Sits between fetch/register-read and the execute stage; its out_alu_* outputs drive the ALU inputs directly.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  PC of in_instr
- in_rs1_data  in  32  register-file value of rs1
- in_rs2_data  in  32  register-file value of rs2
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage accepts head
- out_alu_op  out  t_alu_op  ALU operation (pkg encoding)
- out_alu_in1  out  32  ALU operand 1
- out_alu_in2  out  32  ALU operand 2
- out_rd  out  5  destination register
- out_rd_we  out  1  writeback enable
- out_illegal  out  1  instruction not decodable by this stage

Behaviour:
- Interface (already decided): one clock clk; rst is synchronous and active-high.
- Decode, applied to in_instr at accept:
  - opcode 0110011 (OP): funct3/funct7 maps to ADD/SUB (f7 0100000)/SLL/SLT/SLTU/XOR/SRL/SRA (f7 0100000)/OR/AND. in1=rs1_data, in2=rs2_data. Any other funct7 is illegal.
  - opcode 0010011 (OP-IMM): same map without SUB. in2 = sign-extended instr[31:20]. SLLI requires f7=0000000. SRLI/SRAI require f7 = 0000000/0100000, and in2 = zero-extended shamt instr[24:20]. Otherwise illegal.
  - 0110111 (LUI): ADD, in1=0, in2={instr[31:12],12'b0}.
  - 0010111 (AUIPC): ADD, in1=in_pc, in2={instr[31:12],12'b0}.
  - Any other opcode, or any illegal case above: op=ALU_ADD, in1=in2=0, rd_we=0, illegal=1.
- rd = instr[11:7]. rd_we=1 for legal instructions with rd!=0, else 0.
- Handshake:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Output fields are stable while out_valid=1 and out_ready=0.
  - Latency: an instruction accepted in cycle N is visible at the outputs in cycle N+1 (if the buffer was empty).
- Buffer: head and skid registers. State machine EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept with no pop -> TWO. Pop with no accept -> EMPTY. Accept and pop together -> ONE (new entry becomes head).
  - TWO: pop -> ONE (skid moves to head). No input is accepted in TWO.
- in_ready is a registered signal, =1 when state!=TWO. There is no combinational path from out_ready to in_ready.
- out_valid = (state!=EMPTY). Order is strictly FIFO.
- flush: next state EMPTY, out_valid=0 next cycle. An input transferred in the flush cycle is discarded. flush has priority over accept and pop.
- Reset (rst=1 at edge): state EMPTY, out_valid=0, in_ready=1 after the edge, out_alu_op=ALU_ADD, all other data outputs 0. rst overrides flush and handshakes. Reset mid-operation discards both entries.
- Registers capture decoded fields only on accept. No X propagates from in_* when in_valid=0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=ALU_ADD, in1=5, in2=7, rd=3, rd_we=1.
- ADDI x1,x0,-1 (0xFFF00093) -> in2=0xFFFFFFFF. SRAI x5,x6,4 (0x40435293) -> op=ALU_SRA, in2=4.
- LUI x10,0x12345 (0x12345537) -> in1=0, in2=0x12345000. AUIPC x1,1 (0x00001097) at pc=0x100 -> op=ALU_ADD, in1=0x100, in2=0x1000.
- out_ready=0, drive three back-to-back instructions -> first two accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> heads emerge in order, third accepted once state leaves TWO.
- 0x00000000 -> out_illegal=1, rd_we=0, in1=in2=0. ADD x0,x1,x2 -> rd_we=0, illegal=0.
- State TWO then flush=1 with in_valid=1 -> out_valid=0 and in_ready=1 next cycle, flushed-cycle input never appears. Repeat with rst instead of flush -> all outputs at reset values.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into an ALU
// operation plus two operands, held in a 2-entry FIFO (head + skid) toward execute.

package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } t_alu_op;
endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output t_alu_op         out_alu_op,
    output logic [XLEN-1:0] out_alu_in1,
    output logic [XLEN-1:0] out_alu_in2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        t_alu_op         op;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t dec;
    logic   legal;
    t_alu_op op_sel;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       accept;
    logic       pop;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Handshake: a transfer happens on a side exactly when its valid and ready
    // are both high at the rising edge; the head entry holds still while
    // out_valid=1 and out_ready=0. in_ready depends on state only.
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_ready  = (state != S_TWO);
    assign out_valid = (state != S_EMPTY);

    always_comb begin
        op_sel = ALU_ADD;
        case (f3)
            3'b000:  op_sel = (opcode == OPC_OP && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  op_sel = ALU_SLL;
            3'b010:  op_sel = ALU_SLT;
            3'b011:  op_sel = ALU_SLTU;
            3'b100:  op_sel = ALU_XOR;
            3'b101:  op_sel = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  op_sel = ALU_OR;
            default: op_sel = ALU_AND;
        endcase
    end

    always_comb begin
        dec    = '0;
        dec.op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.op  = op_sel;
                dec.in1 = in_rs1_data;
                dec.in2 = in_rs2_data;
                legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OPIMM: begin
                dec.op  = op_sel;
                dec.in1 = in_rs1_data;
                dec.in2 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediates take only the 5-bit shamt as operand.
                    dec.in2 = {27'd0, in_instr[24:20]};
                    legal   = (f7 == F7_BASE) || (f3 == 3'b101 && f7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                dec.in2 = {in_instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                dec.in1 = in_pc;
                dec.in2 = {in_instr[31:12], 12'd0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op  = ALU_ADD;
            dec.in1 = '0;
            dec.in2 = '0;
        end
        dec.rd      = in_instr[11:7];
        dec.rd_we   = legal && (in_instr[11:7] != 5'd0);
        dec.illegal = !legal;
    end

    // ALU_ADD encodes as zero, so an all-zero entry is the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        head  <= dec;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        head <= dec;
                    end else if (accept) begin
                        skid  <= dec;
                        state <= S_TWO;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign out_alu_op  = head.op;
    assign out_alu_in1 = head.in1;
    assign out_alu_in2 = head.in2;
    assign out_rd      = head.rd;
    assign out_rd_we   = head.rd_we;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode table, backpressure/flush/reset
// sequences, then random traffic against a queue-based reference model.

module tb_alu_issue;
    import alu_issue_pkg::*;

    typedef struct packed {
        t_alu_op     op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } entry_t;

    localparam int EW = $bits(entry_t);

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        entry_t      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    t_alu_op     out_alu_op;
    logic [31:0] out_alu_in1, out_alu_in2;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    alu_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_alu_in1(out_alu_in1), .out_alu_in2(out_alu_in2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- helpers ----------------
    function automatic entry_t mk(t_alu_op op, logic [31:0] a, logic [31:0] b,
                                  logic [4:0] rd, logic we, logic ill);
        entry_t e;
        e.op = op; e.in1 = a; e.in2 = b; e.rd = rd; e.rd_we = we; e.illegal = ill;
        return e;
    endfunction

    function automatic entry_t actual();
        return mk(out_alu_op, out_alu_in1, out_alu_in2, out_rd, out_rd_we, out_illegal);
    endfunction

    task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc,
                         logic [31:0] a, logic [31:0] b);
        in_valid = v; in_instr = instr; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
    endtask

    // Reference decode written straight from the ISA rules.
    function automatic entry_t model_decode(logic [31:0] instr, logic [31:0] pc,
                                            logic [31:0] a, logic [31:0] b);
        t_alu_op base [8];
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] imm_i, imm_u;
        logic ok, is_shift;
        t_alu_op op;
        logic [31:0] x, y;
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
        imm_i = 32'(signed'(instr[31:20]));
        imm_u = instr & 32'hFFFF_F000;
        is_shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok = 1'b0; op = ALU_ADD; x = 0; y = 0;
        if (opc == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            op = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : base[f3];
            x = a; y = b;
        end else if (opc == 7'h13) begin
            ok = !is_shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
            op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : base[f3];
            x = a; y = is_shift ? 32'(instr[24:20]) : imm_i;
        end else if (opc == 7'h37) begin
            ok = 1'b1; x = 0; y = imm_u;
        end else if (opc == 7'h17) begin
            ok = 1'b1; x = pc; y = imm_u;
        end
        if (!ok) begin op = ALU_ADD; x = 0; y = 0; end
        return mk(op, x, y, instr[11:7], ok && instr[11:7] != 0, !ok);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4:    w[6:0] = $urandom_range(0, 1) ? 7'h37 : 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- directed table ----------------
    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"add",      32'h002081B3, 32'h0,   32'd5,   32'd7,  mk(ALU_ADD, 5, 7, 3, 1, 0)};
        vecs[1]  = '{"addi_m1",  32'hFFF00093, 32'h0,   32'd0,   32'd9,  mk(ALU_ADD, 0, 32'hFFFF_FFFF, 1, 1, 0)};
        vecs[2]  = '{"srai",     32'h40435293, 32'h0,   32'h80,  32'd1,  mk(ALU_SRA, 32'h80, 4, 5, 1, 0)};
        vecs[3]  = '{"lui",      32'h12345537, 32'h0,   32'd11,  32'd12, mk(ALU_ADD, 0, 32'h1234_5000, 10, 1, 0)};
        vecs[4]  = '{"auipc",    32'h00001097, 32'h100, 32'd3,   32'd4,  mk(ALU_ADD, 32'h100, 32'h1000, 1, 1, 0)};
        vecs[5]  = '{"zero_ill", 32'h00000000, 32'h40,  32'd3,   32'd4,  mk(ALU_ADD, 0, 0, 0, 0, 1)};
        vecs[6]  = '{"add_x0",   32'h00208033, 32'h0,   32'd8,   32'd9,  mk(ALU_ADD, 8, 9, 0, 0, 0)};
        vecs[7]  = '{"sub",      32'h40208233, 32'h0,   32'd20,  32'd6,  mk(ALU_SUB, 20, 6, 4, 1, 0)};
        vecs[8]  = '{"sltu",     32'h0020B333, 32'h0,   32'd1,   32'd2,  mk(ALU_SLTU, 1, 2, 6, 1, 0)};
        vecs[9]  = '{"op_f7ill", 32'h02208033, 32'h0,   32'd1,   32'd2,  mk(ALU_ADD, 0, 0, 0, 0, 1)};
        vecs[10] = '{"slli_ill", 32'h40309113, 32'h0,   32'd1,   32'd2,  mk(ALU_ADD, 0, 0, 2, 0, 1)};
        vecs[11] = '{"andi",     32'h0F00F493, 32'h0,   32'hFF,  32'd2,  mk(ALU_AND, 32'hFF, 32'hF0, 9, 1, 0)};
    end

    // ---------------- main test ----------------
    initial begin : main
        entry_t e1, e2, e3;
        logic acc, pop, fl;
        logic [31:0] ri, rp, ra, rb;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_valid", EW'(out_valid), EW'(0));
        check("reset_ready", EW'(in_ready), EW'(1));
        check("reset_data", actual(), '0);

        // directed table, one instruction at a time with out_ready=1
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            step();
            drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            @(posedge clk);
            #1 drive(1'b0, $urandom, $urandom, $urandom, $urandom);
            @(negedge clk);
            check({vecs[i].name, "_valid"}, EW'(out_valid), EW'(1));
            check(vecs[i].name, actual(), vecs[i].exp);
        end
        step();

        // backpressure: three back-to-back, only two fit
        e1 = model_decode(32'h002081B3, 0, 1, 2);
        e2 = model_decode(32'h40208233, 0, 3, 4);
        e3 = model_decode(32'h12345537, 0, 5, 6);
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 0, 1, 2);
        step();
        check("bp_head1", actual(), e1);
        check("bp_ready1", EW'(in_ready), EW'(1));
        drive(1'b1, 32'h40208233, 0, 3, 4);
        step();
        check("bp_ready_full", EW'(in_ready), EW'(0));
        drive(1'b1, 32'h12345537, 0, 5, 6);
        step();
        check("bp_ready_hold", EW'(in_ready), EW'(0));
        check("bp_head_stable", actual(), e1);
        out_ready = 1'b1;
        step();
        check("bp_head2", actual(), e2);
        check("bp_ready_reopen", EW'(in_ready), EW'(1));
        step();
        check("bp_head3", actual(), e3);
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("bp_drained", EW'(out_valid), EW'(0));

        // flush from TWO with a pending input, then from ONE with a real transfer
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 0, 1, 2); step();
        drive(1'b1, 32'h40208233, 0, 3, 4); step();
        drive(1'b1, 32'h12345537, 0, 5, 6); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 0, 0, 0, 0);
        check("flush2_valid", EW'(out_valid), EW'(0));
        check("flush2_ready", EW'(in_ready), EW'(1));
        step();
        check("flush2_after", EW'(out_valid), EW'(0));
        drive(1'b1, 32'h002081B3, 0, 1, 2); step();
        drive(1'b1, 32'h40208233, 0, 3, 4); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 0, 0, 0, 0);
        check("flush1_valid", EW'(out_valid), EW'(0));
        step();
        check("flush1_after", EW'(out_valid), EW'(0));

        // reset mid-operation
        drive(1'b1, 32'h002081B3, 0, 1, 2); step();
        drive(1'b1, 32'h40208233, 0, 3, 4); step();
        drive(1'b1, 32'h12345537, 0, 5, 6); rst = 1'b1; flush = 1'b1; step();
        rst = 1'b0; flush = 1'b0; drive(1'b0, 0, 0, 0, 0);
        check("rst_valid", EW'(out_valid), EW'(0));
        check("rst_ready", EW'(in_ready), EW'(1));
        check("rst_data", actual(), '0);

        // random traffic against the queue model
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_valid", EW'(out_valid), EW'(exp_q.size() > 0));
            check("rnd_ready", EW'(in_ready), EW'(exp_q.size() < 2));
            if (exp_q.size() > 0) check("rnd_head", actual(), exp_q[0]);
            ri = rand_instr(); rp = $urandom; ra = $urandom; rb = $urandom;
            drive($urandom_range(0, 9) < 7, ri, rp, ra, rb);
            out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 99) < 3;
            acc = in_valid && exp_q.size() < 2;
            pop = out_ready && exp_q.size() > 0;
            fl = flush;
            step();
            if (fl) exp_q.delete();
            else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(model_decode(ri, rp, ra, rb));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
